// File: rtl/fetch_buffer.sv
// Dual-issue fetch-to-decode instruction queue: compacts valid fetch slots into a
// circular buffer and presents the two oldest entries to decode in program order.
package fetch_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [5:0]  ecode;
    } fetch_to_decode_bus_t;
endpackage

module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 fetch_valid,
    input  fetch_to_decode_bus_t fetch_bus1,
    input  fetch_to_decode_bus_t fetch_bus2,
    output logic                 fb_allowin,
    input  logic                 ds_allowin,
    output logic                 fs_to_valid,
    output fetch_to_decode_bus_t fetch_to_decode_bus1,
    output fetch_to_decode_bus_t fetch_to_decode_bus2
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0] CNT_TWO    = (AW+1)'(2);
    localparam logic [AW:0] ALLOW_MAX  = (AW+1)'(DEPTH - 2);

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    fetch_to_decode_bus_t mem_q [DEPTH];

    logic [AW-1:0] head_nx, tail_nx;
    logic          push, pop;
    logic [1:0]    n_in, n_out;
    logic          wr0_en, wr1_en;
    fetch_to_decode_bus_t wr0_data;

    assign head_nx = head_q + AW'(1);
    assign tail_nx = tail_q + AW'(1);

    // Outputs depend only on registered state, never on this cycle's inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        fs_to_valid          = (count_q != '0);
        fb_allowin           = (count_q <= ALLOW_MAX);
        fetch_to_decode_bus1 = '0;
        fetch_to_decode_bus2 = '0;
        if (count_q >= CNT_ONE) begin
            fetch_to_decode_bus1       = mem_q[head_q];
            fetch_to_decode_bus1.valid = 1'b1;
        end
        if (count_q >= CNT_TWO) begin
            fetch_to_decode_bus2       = mem_q[head_nx];
            fetch_to_decode_bus2.valid = 1'b1;
        end
    end

    always_comb begin
        push     = fetch_valid && fb_allowin && !flush;
        pop      = fs_to_valid && ds_allowin && !flush;
        n_in     = {1'b0, fetch_bus1.valid} + {1'b0, fetch_bus2.valid};
        n_out    = (count_q >= CNT_TWO) ? 2'd2 : count_q[1:0];
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = fetch_bus1;

        // A lone younger slot is compacted down to the tail position.
        if (push) begin
            if (fetch_bus1.valid) begin
                wr0_en = 1'b1;
                wr1_en = fetch_bus2.valid;
            end else if (fetch_bus2.valid) begin
                wr0_en   = 1'b1;
                wr0_data = fetch_bus2;
            end
        end

        tail_d  = tail_q + (push ? AW'(n_in) : '0);
        head_d  = head_q + (pop ? AW'(n_out) : '0);
        count_d = count_q + (push ? (AW+1)'(n_in) : '0) - (pop ? (AW+1)'(n_out) : '0);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; validity is carried entirely by count, so clearing it would be wasted logic.
    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[tail_q]  <= wr0_data;
        if (wr1_en) mem_q[tail_nx] <= fetch_bus2;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a negedge scoreboard tracks every accepted
// slot and checks each popped pair; directed steps add hand-computed checks.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic resetn, flush, fetch_valid, ds_allowin;
    fetch_to_decode_bus_t fetch_bus1, fetch_bus2;
    logic fb_allowin, fs_to_valid;
    fetch_to_decode_bus_t out1, out2;

    int vectors = 0;
    int miscompares = 0;
    fetch_to_decode_bus_t sb[$];

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .flush                (flush),
        .fetch_valid          (fetch_valid),
        .fetch_bus1           (fetch_bus1),
        .fetch_bus2           (fetch_bus2),
        .fb_allowin           (fb_allowin),
        .ds_allowin           (ds_allowin),
        .fs_to_valid          (fs_to_valid),
        .fetch_to_decode_bus1 (out1),
        .fetch_to_decode_bus2 (out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic fetch_to_decode_bus_t mk(input logic v, input logic [31:0] pc);
        fetch_to_decode_bus_t b;
        b.valid = v;
        b.pc    = pc;
        b.inst  = ~pc;
        b.excp  = pc[4];
        b.ecode = pc[7:2];
        return b;
    endfunction

    // Drive one cycle of inputs just after a rising edge, then advance past the next one.
    task automatic step(input logic fv, input logic v1, input logic [31:0] pc1,
                        input logic v2, input logic [31:0] pc2,
                        input logic ds, input logic fl);
        fetch_valid = fv;
        fetch_bus1  = mk(v1, pc1);
        fetch_bus2  = mk(v2, pc2);
        ds_allowin  = ds;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ds);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ds, 1'b0);
    endtask

    // Scoreboard monitor: compare presented pair on each pop, then apply this cycle's push/pop/flush.
    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
        end else begin
            automatic bit allow = (DEPTH - sb.size()) >= 2;
            fetch_to_decode_bus_t e;
            check("sb_fs_to_valid", fs_to_valid, sb.size() != 0);
            check("sb_fb_allowin", fb_allowin, allow);
            if (!flush && ds_allowin && sb.size() != 0) begin
                e = sb.pop_front();
                e.valid = 1'b1;
                check("sb_bus1", out1, e);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    e.valid = 1'b1;
                    check("sb_bus2", out2, e);
                end else begin
                    check("sb_bus2_empty", out2, '0);
                end
            end
            if (!flush && fetch_valid && allow) begin
                if (fetch_bus1.valid) sb.push_back(fetch_bus1);
                if (fetch_bus2.valid) sb.push_back(fetch_bus2);
            end
            if (flush) sb.delete();
        end
    end

    initial begin
        resetn      = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        ds_allowin  = 1'b0;
        fetch_bus1  = '0;
        fetch_bus2  = '0;

        // Power-on reset
        idle(1'b0);
        idle(1'b0);
        check("rst_fs_to_valid", fs_to_valid, 1'b0);
        check("rst_fb_allowin", fb_allowin, 1'b1);
        check("rst_bus1", out1, '0);
        check("rst_bus2", out2, '0);
        resetn = 1'b1;
        idle(1'b0);

        // Mid-stream asynchronous reset clears without a clock edge
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h14, 1'b0, 1'b0);
        check("pre_rst_valid", fs_to_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_fs_to_valid", fs_to_valid, 1'b0);
        check("async_rst_fb_allowin", fb_allowin, 1'b1);
        check("async_rst_bus1", out1, '0);
        check("async_rst_bus2", out2, '0);
        idle(1'b1);
        idle(1'b1);
        resetn = 1'b1;
        idle(1'b0);
        check("post_rst_fs_to_valid", fs_to_valid, 1'b0);

        // Single push, visible next cycle, popped as a pair
        step(1'b1, 1'b1, 32'hBFC00000, 1'b1, 32'hBFC00004, 1'b0, 1'b0);
        check("push_fs_to_valid", fs_to_valid, 1'b1);
        check("push_bus1_pc", out1.pc, 32'hBFC00000);
        check("push_bus2_pc", out2.pc, 32'hBFC00004);
        check("push_bus2_valid", out2.valid, 1'b1);
        idle(1'b1);
        check("pop_empty", fs_to_valid, 1'b0);

        // Compaction of invalid slots
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0);
        check("cmp_bus1_pc", out1.pc, 32'h100);
        check("cmp_bus2_valid0", out2.valid, 1'b0);
        step(1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
        check("cmp_pair_bus1", out1.pc, 32'h100);
        check("cmp_pair_bus2", out2.pc, 32'h104);
        idle(1'b1);
        check("cmp_drained", fs_to_valid, 1'b0);

        // Fill with decode stalled; fifth bundle must be held off
        step(1'b1, 1'b1, 32'h200, 1'b1, 32'h204, 1'b0, 1'b0);
        check("fill1_allowin", fb_allowin, 1'b1);
        step(1'b1, 1'b1, 32'h208, 1'b1, 32'h20C, 1'b0, 1'b0);
        check("fill2_allowin", fb_allowin, 1'b1);
        step(1'b1, 1'b1, 32'h210, 1'b1, 32'h214, 1'b0, 1'b0);
        check("fill3_allowin", fb_allowin, 1'b1);
        step(1'b1, 1'b1, 32'h218, 1'b1, 32'h21C, 1'b0, 1'b0);
        check("fill4_allowin", fb_allowin, 1'b0);
        step(1'b1, 1'b1, 32'h220, 1'b1, 32'h224, 1'b0, 1'b0);
        check("hold1_allowin", fb_allowin, 1'b0);
        check("hold1_head", out1.pc, 32'h200);
        step(1'b1, 1'b1, 32'h220, 1'b1, 32'h224, 1'b1, 1'b0);
        check("release_allowin", fb_allowin, 1'b1);
        check("release_head", out1.pc, 32'h208);
        step(1'b1, 1'b1, 32'h220, 1'b1, 32'h224, 1'b1, 1'b0);
        check("accept5_head", out1.pc, 32'h210);
        idle(1'b1);
        idle(1'b1);
        check("drain_tail_bus1", out1.pc, 32'h220);
        check("drain_tail_bus2", out2.pc, 32'h224);
        idle(1'b1);
        check("fill_drained", fs_to_valid, 1'b0);

        // Move head to 7 with one entry, then push 2 + pop across the wrap
        step(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h304, 1'b0, 1'b0);
        check("odd_bus1_pc", out1.pc, 32'h304);
        check("odd_bus2_valid", out2.valid, 1'b0);
        step(1'b1, 1'b1, 32'h308, 1'b1, 32'h30C, 1'b1, 1'b0);
        check("wrap_bus1_pc", out1.pc, 32'h308);
        check("wrap_bus2_pc", out2.pc, 32'h30C);
        check("wrap_bus2_valid", out2.valid, 1'b1);
        idle(1'b1);
        check("wrap_drained", fs_to_valid, 1'b0);

        // Flush beats a simultaneous push and pop
        step(1'b1, 1'b1, 32'h400, 1'b1, 32'h404, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h408, 1'b1, 32'h40C, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h410, 1'b0, 32'h0, 1'b0, 1'b0);
        check("cnt5_allowin", fb_allowin, 1'b1);
        step(1'b1, 1'b1, 32'h500, 1'b1, 32'h504, 1'b1, 1'b1);
        check("flush_fs_to_valid", fs_to_valid, 1'b0);
        check("flush_fb_allowin", fb_allowin, 1'b1);
        check("flush_bus1", out1, '0);
        check("flush_bus2", out2, '0);
        idle(1'b1);
        check("flush_still_empty", fs_to_valid, 1'b0);
        step(1'b1, 1'b1, 32'h600, 1'b1, 32'h604, 1'b0, 1'b0);
        check("post_flush_bus1", out1.pc, 32'h600);
        check("post_flush_bus2", out2.pc, 32'h604);
        idle(1'b1);
        check("post_flush_drained", fs_to_valid, 1'b0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
